// File: rtl/time_of_day_counter.sv
// BCD time-of-day counter driven by the 1 Hz timebase, with minute/hour set buttons.
// Edges are registered one stage ahead of the time update.
module time_of_day_counter #(
    parameter bit HOUR_24 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_wrap
);

    localparam logic [7:0] HOUR_RST = HOUR_24 ? 8'h00 : 8'h12;

    logic sig_h, min_h, hour_h;
    logic tick_e, min_e, hour_e;

    logic [7:0] sec_r, min_r, hour_r;
    logic       pm_r, pulse_r, wrap_r;

    logic [7:0] sec_n, min_n, hour_n;
    logic       pm_n, pulse_n, wrap_n;

    logic [7:0] min_adv, hour_adv;
    logic       pm_adv, day_adv;

    // Two-digit BCD increment without range wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {4'(v[7:4] + 4'd1), 4'd0};
        else
            return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    // History tracks the input even in reset, so a level held across release gives no edge.
    always_ff @(posedge clk) begin
        sig_h  <= signal;
        min_h  <= inc_min;
        hour_h <= inc_hour;
        if (reset) begin
            tick_e <= 1'b0;
            min_e  <= 1'b0;
            hour_e <= 1'b0;
        end else begin
            tick_e <= signal & ~sig_h;
            min_e  <= inc_min & ~min_h;
            hour_e <= inc_hour & ~hour_h;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_r   <= 8'h00;
            min_r   <= 8'h00;
            hour_r  <= HOUR_RST;
            pm_r    <= 1'b0;
            pulse_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            sec_r   <= sec_n;
            min_r   <= min_n;
            hour_r  <= hour_n;
            pm_r    <= pm_n;
            pulse_r <= pulse_n;
            wrap_r  <= wrap_n;
        end
    end

    // Single-step successors of minutes and hours, shared by tick carries and set buttons.
    always_comb begin
        min_adv  = (min_r == 8'h59) ? 8'h00 : bcd_inc(min_r);
        hour_adv = bcd_inc(hour_r);
        pm_adv   = pm_r;
        day_adv  = 1'b0;
        if (HOUR_24) begin
            if (hour_r == 8'h23) begin
                hour_adv = 8'h00;
                day_adv  = 1'b1;
            end
        end else begin
            if (hour_r == 8'h12) begin
                hour_adv = 8'h01;
            end else if (hour_r == 8'h11) begin
                pm_adv  = ~pm_r;
                day_adv = pm_r;
            end
        end
    end

    // A set edge takes precedence and swallows a coincident tick.
    always_comb begin
        sec_n   = sec_r;
        min_n   = min_r;
        hour_n  = hour_r;
        pm_n    = pm_r;
        pulse_n = 1'b0;
        wrap_n  = 1'b0;
        if (min_e || hour_e) begin
            if (min_e) begin
                min_n = min_adv;
                sec_n = 8'h00;
            end
            if (hour_e) begin
                hour_n = hour_adv;
                pm_n   = pm_adv;
            end
        end else if (tick_e) begin
            pulse_n = 1'b1;
            if (sec_r == 8'h59) begin
                sec_n = 8'h00;
                min_n = min_adv;
                if (min_r == 8'h59) begin
                    hour_n = hour_adv;
                    pm_n   = pm_adv;
                    wrap_n = day_adv;
                end
            end else begin
                sec_n = bcd_inc(sec_r);
            end
        end
    end

    assign sec_bcd   = sec_r;
    assign min_bcd   = min_r;
    assign hour_bcd  = hour_r;
    assign pm        = pm_r;
    assign sec_pulse = pulse_r;
    assign day_wrap  = wrap_r;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Drives a 24-hour and a 12-hour counter with shared inputs and checks both
// against a seconds-of-day reference model.
module tb_time_of_day_counter;

    logic clk, reset, signal, inc_min, inc_hour;
    logic [7:0] sec24, min24, hour24, sec12, min12, hour12;
    logic pm24, sp24, dw24, pm12, sp12, dw12;

    time_of_day_counter #(.HOUR_24(1'b1)) dut24 (
        .clk(clk), .reset(reset), .signal(signal), .inc_min(inc_min), .inc_hour(inc_hour),
        .sec_bcd(sec24), .min_bcd(min24), .hour_bcd(hour24), .pm(pm24),
        .sec_pulse(sp24), .day_wrap(dw24)
    );

    time_of_day_counter #(.HOUR_24(1'b0)) dut12 (
        .clk(clk), .reset(reset), .signal(signal), .inc_min(inc_min), .inc_hour(inc_hour),
        .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12), .pm(pm12),
        .sec_pulse(sp12), .day_wrap(dw12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: 24-hour time as plain integers; the 12-hour view is derived from it.
    int mh = 0, mm = 0, ms = 0;
    int exp_sp = 0, exp_dw = 0;

    // Strobe observation.
    int n_sp24 = 0, n_sp12 = 0, n_dw24 = 0, n_dw12 = 0, werr = 0;
    logic p_sp24 = 1'b0, p_sp12 = 1'b0, p_dw24 = 1'b0, p_dw12 = 1'b0;

    always @(negedge clk) begin
        n_sp24 += int'(sp24);
        n_sp12 += int'(sp12);
        n_dw24 += int'(dw24);
        n_dw12 += int'(dw12);
        if ((sp24 && p_sp24) || (sp12 && p_sp12) || (dw24 && p_dw24) || (dw12 && p_dw12))
            werr++;
        p_sp24 = sp24;
        p_sp12 = sp12;
        p_dw24 = dw24;
        p_dw12 = dw12;
    end

    logic [49:0] obs;
    assign obs = {sec24, min24, hour24, pm24, sec12, min12, hour12, pm12};

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [49:0] expv();
        int h12;
        h12 = (mh % 12 == 0) ? 12 : mh % 12;
        return {bcd(ms), bcd(mm), bcd(mh), 1'b0,
                bcd(ms), bcd(mm), bcd(h12), (mh >= 12)};
    endfunction

    task automatic model_tick();
        exp_sp++;
        ms++;
        if (ms == 60) begin
            ms = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                mh++;
                if (mh == 24) begin
                    mh = 0;
                    exp_dw++;
                end
            end
        end
    endtask

    task automatic model_event(input logic t, input logic m, input logic h);
        if (m || h) begin
            if (m) begin
                mm = (mm + 1) % 60;
                ms = 0;
            end
            if (h) mh = (mh + 1) % 24;
        end else if (t) begin
            model_tick();
        end
    endtask

    // One-cycle pulse on the selected inputs, then wait until the update and strobe are past.
    task automatic ev(input logic t, input logic m, input logic h);
        @(negedge clk);
        signal = t; inc_min = m; inc_hour = h;
        @(negedge clk);
        signal = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_event(t, m, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; signal = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mh = 0; mm = 0; ms = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        repeat (h) ev(1'b0, 1'b0, 1'b1);
        repeat (m) ev(1'b0, 1'b1, 1'b0);
        repeat (s) ev(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL reset_time got=%h want=%h", obs, expv());
        end
        checks++;
        if ({sp24, dw24, sp12, dw12} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=0000", {sp24, dw24, sp12, dw12});
        end
    endtask

    task automatic test_ten_ticks();
        int sp0;
        do_reset();
        sp0 = n_sp24;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            signal = ~signal;
            if (signal) model_tick();
            repeat (19) @(negedge clk);
        end
        checks++;
        if (obs !== expv() || sec24 !== 8'h10 || min24 !== 8'h00) begin
            errors++;
            $display("FAIL ten_ticks_time got=%h want=%h", obs, expv());
        end
        checks++;
        if (n_sp24 - sp0 !== 10 || n_sp12 !== n_sp24 || werr !== 0) begin
            errors++;
            $display("FAIL ten_ticks_pulses got=%0d width_err=%0d want=10 width_err=0",
                     n_sp24 - sp0, werr);
        end
    endtask

    task automatic test_day_wrap();
        int dw0;
        set_time(23, 59, 58);
        checks++;
        if (obs !== expv() || hour24 !== 8'h23 || sec24 !== 8'h58) begin
            errors++;
            $display("FAIL preset_235958 got=%h want=%h", obs, expv());
        end
        dw0 = n_dw24;
        ev(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== expv() || n_dw24 !== dw0) begin
            errors++;
            $display("FAIL tick_235959 got=%h dw=%0d want=%h dw=%0d", obs, n_dw24 - dw0, expv(), 0);
        end
        ev(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== expv() || hour24 !== 8'h00 || n_dw24 - dw0 !== 1 || n_dw12 - dw0 !== 1 || werr !== 0) begin
            errors++;
            $display("FAIL day_wrap got=%h dw=%0d want=%h dw=1", obs, n_dw24 - dw0, expv());
        end
    endtask

    task automatic test_twelve_hour();
        int hs[3] = '{11, 12, 23};
        foreach (hs[i]) begin
            set_time(hs[i], 59, 59);
            ev(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== expv() || n_dw24 !== exp_dw || n_dw12 !== exp_dw) begin
                errors++;
                $display("FAIL h12_rollover_%0d got=%h dw=%0d want=%h dw=%0d",
                         hs[i], obs, n_dw12, expv(), exp_dw);
            end
        end
    endtask

    task automatic test_set_vs_tick();
        int sp0;
        set_time(0, 59, 30);
        sp0 = n_sp24;
        ev(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== expv() || min24 !== 8'h00 || hour24 !== 8'h00 || sec24 !== 8'h00) begin
            errors++;
            $display("FAIL set_min_with_tick got=%h want=%h", obs, expv());
        end
        checks++;
        if (n_sp24 !== sp0 || n_sp12 !== sp0) begin
            errors++;
            $display("FAIL set_min_tick_pulse got=%0d want=%0d", n_sp24, sp0);
        end
        ev(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL set_both got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_held_levels();
        int sp0;
        @(negedge clk);
        signal = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mh = 0; mm = 0; ms = 0;
        sp0 = n_sp24;
        repeat (10) @(negedge clk);
        checks++;
        if (obs !== expv() || n_sp24 !== sp0) begin
            errors++;
            $display("FAIL held_signal got=%h pulses=%0d want=%h pulses=0", obs, n_sp24 - sp0, expv());
        end
        signal = 1'b0;
        ev(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== expv() || n_sp24 - sp0 !== 1) begin
            errors++;
            $display("FAIL signal_reedge got=%h pulses=%0d want=%h pulses=1", obs, n_sp24 - sp0, expv());
        end
        @(negedge clk);
        inc_hour = 1'b1;
        repeat (100) @(negedge clk);
        inc_hour = 1'b0;
        repeat (3) @(negedge clk);
        model_event(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL held_inc_hour got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_reset_mid_count();
        set_time(5, 30, 17);
        @(negedge clk);
        signal = 1'b1;
        @(negedge clk);
        reset = 1'b1; signal = 1'b0;
        @(negedge clk);
        mh = 0; mm = 0; ms = 0;
        checks++;
        if (obs !== expv() || {sp24, dw24, sp12, dw12} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_count got=%h strobes=%b want=%h strobes=0000",
                     obs, {sp24, dw24, sp12, dw12}, expv());
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] r;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = 3'($urandom_range(0, 7));
            if (r[2:1] == 2'b00 && $urandom_range(0, 3) != 0) r[0] = 1'b1;
            ev(r[0], r[1], r[2]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (obs !== expv() || n_sp24 !== exp_sp || n_sp12 !== exp_sp ||
                n_dw24 !== exp_dw || werr !== 0) begin
                errors++;
                $display("FAIL random_%0d ev=%b got=%h sp=%0d want=%h sp=%0d",
                         i, r, obs, n_sp24, expv(), exp_sp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; signal = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ten_ticks();
        test_day_wrap();
        test_twelve_hour();
        test_set_vs_tick();
        test_held_levels();
        test_reset_mid_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Consumer end of the 1 Hz timebase: samples the `signal` output of one_hertz_gen and counts seconds, minutes and hours in BCD.
- Feeds the 7-segment display driver.
- Two debounced push-button levels set minutes and hours.
- Runs on the board's 12 MHz clock domain; all inputs are already synchronous to `clk`.

Parameters:
- HOUR_24, 1, 1 = 24-hour count (00..23); 0 = 12-hour count (01..12) with AM/PM flag.

Ports:
- clk  input  1  system clock (12 MHz).
- reset  input  1  synchronous, active-high reset.
- signal  input  1  1 Hz level from one_hertz_gen; a rising edge is one second.
- inc_min  input  1  debounced level; a rising edge advances minutes.
- inc_hour  input  1  debounced level; a rising edge advances hours.
- sec_bcd  output  8  seconds, [7:4] tens 0..5, [3:0] units 0..9.
- min_bcd  output  8  minutes, same encoding.
- hour_bcd  output  8  hours, [7:4] tens 0..2, [3:0] units 0..9.
- pm  output  1  12-hour mode PM flag; tied 0 when HOUR_24=1.
- sec_pulse  output  1  one-cycle strobe, high in the cycle the time registers take a tick-driven update.
- day_wrap  output  1  one-cycle strobe on the day rollover.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`reset`); all state is updated on the rising edge of `clk`.
- Edge detection:
  - One history register each for signal, inc_min and inc_hour.
  - edge = input & ~history.
  - During reset, each history register loads the current input value, so an input held high across reset release gives no edge.
- Reset values:
  - sec_bcd = 8'h00, min_bcd = 8'h00.
  - hour_bcd = 8'h00 if HOUR_24=1, else 8'h12.
  - pm = 0, sec_pulse = 0, day_wrap = 0.
- Tick edge with no set edge in the same cycle:
  - Seconds advance; 59 -> 00 carries into minutes.
  - Minutes 59 -> 00 carries into hours.
  - Hours, 24h: 23 -> 00 raises day_wrap.
  - Hours, 12h: 11 -> 12 toggles pm; pm 1 -> 0 raises day_wrap. 12 -> 01 has no pm change.
  - All carries resolve in the same cycle; sec_pulse = 1 in that cycle.
- BCD rules:
  - Units 9 -> 0 increments tens.
  - Tens wrap at the limits above.
  - Never emit a non-BCD digit (A..F) or an out-of-range value.
- inc_min edge:
  - Minutes +1, 59 -> 00 with no carry into hours.
  - Seconds cleared to 00.
- inc_hour edge:
  - Hours +1 with the same wrap as above, but no day_wrap.
  - 12h mode still toggles pm on 11 -> 12.
- Simultaneous events:
  - Any set edge in the same cycle as a tick edge: the tick is discarded (sec_pulse = 0, no carry).
  - inc_min and inc_hour together: both applied; seconds cleared.
- Strobe timing:
  - sec_pulse and day_wrap are registered and high exactly one cycle.
  - Both are 0 in every cycle without a qualifying event.
- Level inputs held high generate only one edge; a new edge needs the input to go low for at least 1 cycle.
- Reset mid-count forces the reset values on the next clk edge regardless of other inputs; reset has highest priority.
- Latency: input edge sampled at clk edge N; outputs reflect the new time after edge N+1 (one register stage of edge detection, one update stage).

Test Plan:
- Reset, then 10 tick rising edges (signal toggled every 20 cycles) -> sec_bcd = 8'h10, min_bcd = 8'h00, sec_pulse seen exactly 10 times, each 1 cycle wide.
- Preset to 23:59:58 via inc_hour/inc_min/ticks (HOUR_24=1), then 2 ticks -> 23:59:59, then 00:00:00; day_wrap high exactly 1 cycle on the second tick.
- HOUR_24=0: from 11:59:59 pm=0, 1 tick -> 12:00:00 pm=1. From 12:59:59, 1 tick -> 01:00:00 pm unchanged. From 11:59:59 pm=1, 1 tick -> 12:00:00 pm=0 with day_wrap.
- At 00:59:30, inc_min edge in the same cycle as a tick edge -> 00:00:00 with hours unchanged, seconds 00, sec_pulse = 0 that cycle.
- Hold signal high through reset, release reset -> no sec_pulse until signal goes low then high again; inc_hour held high 100 cycles -> hours +1 only.
- Counting at 05:30:17, assert reset for 1 cycle -> next cycle outputs 00:00:00 (24h), both strobes 0.
